seg_display_driver: RTL

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seg_display_driver.sv
// Purpose: 8-digit hex 7-segment scan driver with a one-deep pending buffer swapped in at frame wrap.
// Latency: anode/segments/frame_done are registered, one cycle after the anodeCounter that selects them.
// Backpressure: load_ready drops while a value is pending; a load offered while it is low is dropped.
module seg_display_driver (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  anodeCounter,
  input  logic [31:0] data_in,
  input  logic        load,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [7:0]  anode,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frame_done
);

  // Display / pending state
  logic [31:0] disp_q, disp_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [2:0]  prev_idx_q, prev_idx_d;

  // Registered outputs
  logic [7:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;
  logic        frame_done_q, frame_done_d;

  // Internal combinational terms
  logic        wrap;
  logic        accept;
  logic [3:0]  nib;
  logic [31:0] upper;
  logic        blank;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Frame wrap, load handshake and digit selection/blanking from the current (pre-update) display value.
  always_comb begin
    wrap       = (prev_idx_q == 3'd7) && (anodeCounter == 3'd0);
    load_ready = !pend_vld_q && !reset;
    accept     = load && load_ready;
    nib        = disp_q[{anodeCounter, 2'b00} +: 4];
    // Everything from the selected digit upwards; zero means this digit is a leading zero.
    upper      = disp_q >> {anodeCounter, 2'b00};
    blank      = blank_lz && (anodeCounter != 3'd0) && (upper == 32'd0);
  end

  // Next-state for the display/pending buffer pair.
  always_comb begin
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    prev_idx_d = anodeCounter;
    // A wrap with a pending value promotes it; accept can only be true when nothing is pending,
    // so the two branches never collide and a load during a promoting wrap is dropped.
    if (wrap && pend_vld_q) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end else if (accept) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
    end
  end

  // Next-state for the registered display outputs.
  always_comb begin
    anode_d      = ~(8'b1 << anodeCounter);
    seg_d        = blank ? 7'h7F : hex7(nib);
    frame_done_d = wrap;
  end

  // State and output registers; reset discards any pending value and blanks the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q       <= 32'd0;
      pend_q       <= 32'd0;
      pend_vld_q   <= 1'b0;
      prev_idx_q   <= 3'd0;
      anode_q      <= 8'hFF;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      prev_idx_q   <= prev_idx_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign segments   = seg_q;
  assign frame_done = frame_done_q;
  // Decimal point is never used.
  assign dp         = 1'b1;

endmodule
